spike_motor_decoder: RTL and testbench
======================================

# spike_motor_decoder

Output-side decoder for the spiking controller: counts spikes from the two excitatory output neurons (left, right) over a fixed window of enable ticks, converts each count to a saturated motor duty value, offers the pair to the motor driver over a valid/ready handshake, and generates one PWM waveform per motor. It sits after the excitatory neurons and turns spike trains back into actuator commands, the inverse of the input neurons' value-to-spike encoding.

## Interface
- CNT_W, 10, spike counter width; counts saturate at 2^CNT_W-1
- WINDOW_TICKS, 20, `tick` pulses per counting window (20 = 1 ms at 20 kHz tick)
- GAIN, 4, integer count-to-duty multiplier, range 1..15
- PWM_W, 8, duty and PWM counter width

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  global enable; low freezes spike counting, window count and PWM counter
- tick  in  1  single-cycle window timebase pulse (20 kHz divider output)
- spike_l  in  1  left excitatory neuron spike
- spike_r  in  1  right excitatory neuron spike
- cmd_valid  out  1  command payload valid
- cmd_ready  in  1  motor driver accepts payload
- cmd_left  out  PWM_W  left duty of last window
- cmd_right  out  PWM_W  right duty of last window
- overrun  out  1  sticky: a window result replaced an unaccepted payload
- pwm_l  out  1  left motor PWM
- pwm_r  out  1  right motor PWM

## Operation
- Spike detection: a spike is a rising edge (input high, registered copy low) sampled while en=1. Edge registers reset to 0.
- Per-channel counters increment by 1 per edge and saturate at 2^CNT_W-1.
- Window counter advances on each cycle with tick=1 and en=1. Window end = tick=1, en=1, window count = WINDOW_TICKS-1; the window counter then wraps to 0.
- At window end the counts are captured into the snapshot registers and the counters restart. A spike edge in the window-end cycle belongs to the new window: that counter loads 1, otherwise 0.
- FSM states:
  - COUNT: idle, cmd_valid=0.
  - SCALE: one cycle; duty = min(snapshot*GAIN, 2^PWM_W-1) per channel. Product width is CNT_W+4 before clamping.
  - HOLD: cmd_valid=1 with the scaled duties.
- Transitions: COUNT -> SCALE at window end; SCALE -> HOLD; HOLD -> COUNT when cmd_ready=1.
- If a window end occurs in HOLD without ready in that cycle, the FSM goes to SCALE and overrun sets. The new payload replaces the old one; valid drops for the SCALE cycle only.
- A window end in the same cycle as an accepting handshake is not an overrun. The FSM goes to SCALE.
- Handshake: the payload is stable while cmd_valid=1 and cmd_ready=0. Transfer occurs when valid and ready are both high. cmd_ready is ignored outside HOLD.
- en=0 does not block the FSM. A pending handshake still completes.
- PWM: a free-running PWM_W counter increments when en=1 and wraps at 2^PWM_W-1.
  - Each channel's active duty register loads the latest scaled duty when the counter is 0, independent of the handshake.
  - pwm_x = (pwm counter < active duty). Duty 0 gives a constant low output. Maximum duty gives a high output for 2^PWM_W-1 of 2^PWM_W cycles.
- overrun clears only on reset.

## Timing
- Reset values: all counters 0, FSM COUNT, cmd_valid=0, cmd_left=cmd_right=0, overrun=0, active duties 0, pwm_l=pwm_r=0.
- Reset is asynchronous; assertion in any state, including mid-HOLD, drops cmd_valid and the PWM outputs immediately.
- Window end in cycle N: snapshot captured at edge N, SCALE in N+1, cmd_valid=1 from N+2.
- With cmd_ready held high, cmd_valid is high for exactly one cycle (N+2).
- Spike-to-count latency: 1 cycle after the edge is sampled.
- A new duty reaches pwm_x at the next PWM counter wrap after cmd_left/right update. Worst case is 2^PWM_W cycles.
- Maximum PWM and command rate: one command per window; PWM period is 2^PWM_W en-cycles.

## Test plan
- Reset/idle: rst low, then release with no spikes and tick every cycle for 60 cycles. Required: three commands 0/0, pwm low, overrun=0.
- Basic decode: tick every cycle, cmd_ready=1, 10 left edges and 3 right edges in window 1. Required: cmd_left=40, cmd_right=12, cmd_valid one cycle exactly 2 cycles after the 20th tick.
- Saturation: tick held 0 while 1100 left edges arrive, then 20 ticks. Required: count clamps to 1023 and cmd_left=255. Separately, 70 edges give 280, so cmd_left=255.
- Backpressure/overrun: cmd_ready=0 across window A (5,5) and window B (7,1). Required: payload 20/20 held stable, then replaced by 28/4, overrun=1. Assert ready and check the transfer and return to COUNT.
- Boundary: a left edge in the window-end cycle. Required: excluded from the closing count and counted as 1 in the next window. A handshake coinciding with a window end does not set overrun.
- PWM and reset: cmd_left=64 gives pwm_l high for 64 of 256 cycles. A duty change mid-period takes effect only after the wrap. en=0 freezes pwm_l. Async rst pulse mid-HOLD clears cmd_valid and pwm outputs within the same cycle.

Source files
------------

// File: rtl/spike_motor_decoder.sv
// rtl/spike_motor_decoder.sv - spike-count window decoder to motor duty command and PWM
// Counts excitatory spikes per window, scales to duty, offers it over valid/ready and drives PWM.
module spike_motor_decoder #(
  parameter int CNT_W        = 10,
  parameter int WINDOW_TICKS = 20,
  parameter int GAIN         = 4,
  parameter int PWM_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  input  logic             spike_l,
  input  logic             spike_r,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [PWM_W-1:0] cmd_left,
  output logic [PWM_W-1:0] cmd_right,
  output logic             overrun,
  output logic             pwm_l,
  output logic             pwm_r
);

  localparam int WIN_W = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
  localparam int PRD_W = CNT_W + 4;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_TICKS - 1);
  localparam logic [PRD_W-1:0] DUTY_MAX = PRD_W'((1 << PWM_W) - 1);

  typedef enum logic [1:0] {S_COUNT, S_SCALE, S_HOLD} state_t;

  state_t           state, state_nx;
  logic             spike_l_q, spike_r_q;
  logic             edge_l, edge_r, win_end, load_cmd;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] cnt_l, cnt_r, snap_l, snap_r;
  logic [PRD_W-1:0] prod_l, prod_r;
  logic [PWM_W-1:0] duty_l, duty_r;
  logic [PWM_W-1:0] pwm_cnt, pwm_nxt, act_l, act_r;

  assign edge_l  = en & spike_l & ~spike_l_q;
  assign edge_r  = en & spike_r & ~spike_r_q;
  assign win_end = tick & en & (win_cnt == WIN_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spike_l_q <= 1'b0;
      spike_r_q <= 1'b0;
      win_cnt   <= '0;
      cnt_l     <= '0;
      cnt_r     <= '0;
      snap_l    <= '0;
      snap_r    <= '0;
    end else begin
      spike_l_q <= spike_l;
      spike_r_q <= spike_r;
      if (tick && en) win_cnt <= win_end ? '0 : win_cnt + 1'b1;
      // An edge coinciding with the window end opens the next window's count.
      if (win_end) begin
        snap_l <= cnt_l;
        snap_r <= cnt_r;
        cnt_l  <= CNT_W'(edge_l);
        cnt_r  <= CNT_W'(edge_r);
      end else begin
        if (edge_l && cnt_l != '1) cnt_l <= cnt_l + 1'b1;
        if (edge_r && cnt_r != '1) cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  assign prod_l = PRD_W'(snap_l) * PRD_W'(GAIN);
  assign prod_r = PRD_W'(snap_r) * PRD_W'(GAIN);
  assign duty_l = (prod_l > DUTY_MAX) ? '1 : prod_l[PWM_W-1:0];
  assign duty_r = (prod_r > DUTY_MAX) ? '1 : prod_r[PWM_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_COUNT;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_COUNT: if (win_end) state_nx = S_SCALE;
      S_SCALE: state_nx = S_HOLD;
      S_HOLD: begin
        if (win_end)        state_nx = S_SCALE;
        else if (cmd_ready) state_nx = S_COUNT;
      end
      default: state_nx = S_COUNT;
    endcase
  end

  always_comb begin
    cmd_valid = (state == S_HOLD);
    load_cmd  = (state == S_SCALE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_left  <= '0;
      cmd_right <= '0;
      overrun   <= 1'b0;
    end else begin
      if (load_cmd) begin
        cmd_left  <= duty_l;
        cmd_right <= duty_r;
      end
      if (state == S_HOLD && win_end && !cmd_ready) overrun <= 1'b1;
    end
  end

  // Outputs are registered against the next counter value so pwm_x tracks (counter < active duty).
  assign pwm_nxt = pwm_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt <= '0;
      act_l   <= '0;
      act_r   <= '0;
      pwm_l   <= 1'b0;
      pwm_r   <= 1'b0;
    end else if (en) begin
      pwm_cnt <= pwm_nxt;
      if (pwm_nxt == '0) begin
        act_l <= cmd_left;
        act_r <= cmd_right;
        pwm_l <= (cmd_left != '0);
        pwm_r <= (cmd_right != '0);
      end else begin
        pwm_l <= (pwm_nxt < act_l);
        pwm_r <= (pwm_nxt < act_r);
      end
    end
  end

endmodule

// File: tb/tb_spike_motor_decoder.sv
// tb/tb_spike_motor_decoder.sv - randomized and directed bench for spike_motor_decoder
// A behavioural window/command/PWM model is stepped each clock and compared every cycle.
module tb_spike_motor_decoder;

  localparam int CNT_W        = 10;
  localparam int WINDOW_TICKS = 20;
  localparam int GAIN         = 4;
  localparam int PWM_W        = 8;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;
  localparam int DUTY_MAX     = (1 << PWM_W) - 1;
  localparam int PWM_PERIOD   = 1 << PWM_W;

  logic             clk, rst, en, tick, spike_l, spike_r, cmd_ready;
  logic             cmd_valid, overrun, pwm_l, pwm_r;
  logic [PWM_W-1:0] cmd_left, cmd_right;

  spike_motor_decoder #(
    .CNT_W(CNT_W), .WINDOW_TICKS(WINDOW_TICKS), .GAIN(GAIN), .PWM_W(PWM_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .spike_l(spike_l), .spike_r(spike_r),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_left(cmd_left), .cmd_right(cmd_right),
    .overrun(overrun), .pwm_l(pwm_l), .pwm_r(pwm_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // model state
  int m_cnt_l, m_cnt_r, m_wc, m_pend_l, m_pend_r, m_cmd_l, m_cmd_r, m_pc, m_act_l, m_act_r;
  bit m_prev_l, m_prev_r, m_valid, m_scale, m_ovr, m_pwm_l, m_pwm_r;

  // observation bookkeeping
  int cyc = 0, n_valid = 0, n_vcyc = 0, valid_at = 0, last_l = -1, last_r = -1;
  bit pv = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int duty_of(input int cnt);
    return (cnt * GAIN > DUTY_MAX) ? DUTY_MAX : cnt * GAIN;
  endfunction

  task automatic model_reset();
    m_cnt_l = 0; m_cnt_r = 0; m_wc = 0; m_pend_l = 0; m_pend_r = 0;
    m_cmd_l = 0; m_cmd_r = 0; m_pc = 0; m_act_l = 0; m_act_r = 0;
    m_prev_l = 0; m_prev_r = 0; m_valid = 0; m_scale = 0; m_ovr = 0;
    m_pwm_l = 0; m_pwm_r = 0;
  endtask

  task automatic model_step();
    bit e_l, e_r, wend, old_valid;
    if (en) begin
      m_pc = (m_pc + 1) % PWM_PERIOD;
      if (m_pc == 0) begin
        m_act_l = m_cmd_l;
        m_act_r = m_cmd_r;
      end
      m_pwm_l = (m_pc < m_act_l);
      m_pwm_r = (m_pc < m_act_r);
    end
    e_l = en && spike_l && !m_prev_l;
    e_r = en && spike_r && !m_prev_r;
    m_prev_l = spike_l;
    m_prev_r = spike_r;
    wend = tick && en && (m_wc == WINDOW_TICKS - 1);
    if (tick && en) m_wc = wend ? 0 : m_wc + 1;
    old_valid = m_valid;
    if (m_scale) begin
      m_cmd_l = m_pend_l;
      m_cmd_r = m_pend_r;
      m_valid = 1;
      m_scale = 0;
    end else if (old_valid && cmd_ready) begin
      m_valid = 0;
    end
    if (wend) begin
      if (old_valid && !cmd_ready) m_ovr = 1;
      m_pend_l = duty_of(m_cnt_l);
      m_pend_r = duty_of(m_cnt_r);
      m_scale = 1;
      m_valid = 0;
      m_cnt_l = e_l;
      m_cnt_r = e_r;
    end else begin
      if (e_l && m_cnt_l < CNT_MAX) m_cnt_l++;
      if (e_r && m_cnt_r < CNT_MAX) m_cnt_r++;
    end
  endtask

  task automatic compare_all();
    check("cmd_valid", cmd_valid, m_valid);
    check("cmd_left", cmd_left, m_cmd_l);
    check("cmd_right", cmd_right, m_cmd_r);
    check("overrun", overrun, m_ovr);
    check("pwm_l", pwm_l, m_pwm_l);
    check("pwm_r", pwm_r, m_pwm_r);
    if (cmd_valid === 1'b1) begin
      if (!pv) begin
        n_valid++;
        valid_at = cyc;
      end
      n_vcyc++;
      last_l = cmd_left;
      last_r = cmd_right;
    end
    pv = (cmd_valid === 1'b1);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_step();
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic drv(input bit e, input bit t, input bit sl, input bit sr, input bit rd);
    en = e; tick = t; spike_l = sl; spike_r = sr; cmd_ready = rd;
    cycle();
  endtask

  task automatic clear_obs();
    n_valid = 0; n_vcyc = 0; last_l = -1; last_r = -1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    en = 0; tick = 0; spike_l = 0; spike_r = 0; cmd_ready = 0;
    repeat (3) cycle();
    rst = 1'b1;
    clear_obs();
  endtask

  // nl/nr edges (<= 10) on even cycles of a 20-tick window
  task automatic run_window(input int nl, input int nr, input bit rd);
    for (int c = 0; c < WINDOW_TICKS; c++)
      drv(1, 1, (c < 2 * nl) && (c % 2 == 0), (c < 2 * nr) && (c % 2 == 0), rd);
  endtask

  task automatic idle(input int n, input bit rd);
    repeat (n) drv(1, 0, 0, 0, rd);
  endtask

  task automatic sat_case(input int n, input int exp_duty);
    do_reset();
    for (int i = 0; i < n; i++) begin
      drv(1, 0, 1, 0, 1);
      drv(1, 0, 0, 0, 1);
    end
    clear_obs();
    run_window(0, 0, 1);
    idle(4, 1);
    check("sat_pulses", n_valid, 1);
    check("sat_left", last_l, exp_duty);
  endtask

  int start, hi;

  initial begin
    rst = 0; en = 0; tick = 0; spike_l = 0; spike_r = 0; cmd_ready = 0;
    model_reset();

    // reset and idle windows
    do_reset();
    check("rst_valid", cmd_valid, 0);
    check("rst_pwm", pwm_l, 0);
    repeat (62) drv(1, 1, 0, 0, 1);
    check("idle_pulses", n_valid, 3);
    check("idle_left", last_l, 0);
    check("idle_right", last_r, 0);
    check("idle_overrun", overrun, 0);

    // basic decode and latency
    do_reset();
    start = cyc;
    run_window(10, 3, 1);
    idle(4, 1);
    check("basic_pulses", n_valid, 1);
    check("basic_vcyc", n_vcyc, 1);
    check("basic_left", last_l, 40);
    check("basic_right", last_r, 12);
    check("basic_latency", valid_at - start, WINDOW_TICKS + 1);

    // saturation of counter and of duty
    sat_case(1100, 255);
    sat_case(70, 255);
    sat_case(50, 200);

    // backpressure and overrun
    do_reset();
    run_window(5, 5, 0);
    idle(3, 0);
    check("bp_a_valid", cmd_valid, 1);
    check("bp_a_left", cmd_left, 20);
    check("bp_a_right", cmd_right, 20);
    check("bp_a_ovr", overrun, 0);
    run_window(7, 1, 0);
    idle(3, 0);
    check("bp_b_left", cmd_left, 28);
    check("bp_b_right", cmd_right, 4);
    check("bp_b_ovr", overrun, 1);
    check("bp_b_valid", cmd_valid, 1);
    idle(1, 1);
    check("bp_xfer_valid", cmd_valid, 0);
    idle(2, 1);
    check("bp_idle_valid", cmd_valid, 0);

    // spike edge in the window-end cycle
    do_reset();
    for (int c = 0; c < WINDOW_TICKS; c++) drv(1, 1, c == WINDOW_TICKS - 1, 0, 1);
    idle(3, 1);
    check("bnd_first", last_l, 0);
    run_window(0, 0, 1);
    idle(3, 1);
    check("bnd_second", last_l, 4);

    // handshake in the same cycle as a window end
    do_reset();
    run_window(1, 1, 0);
    for (int c = 0; c < WINDOW_TICKS; c++) drv(1, 1, 0, 0, c == WINDOW_TICKS - 1);
    idle(3, 1);
    check("hs_ovr", overrun, 0);
    check("hs_left", last_l, 0);

    // PWM duty 64
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drv(1, 0, 1, 0, 1);
      drv(1, 0, 0, 0, 1);
    end
    run_window(0, 0, 1);
    idle(3, 1);
    check("pwm_cmd", cmd_left, 64);
    idle(PWM_PERIOD, 1);
    hi = 0;
    for (int i = 0; i < PWM_PERIOD; i++) begin
      drv(1, 0, 0, 0, 1);
      hi += int'(pwm_l);
    end
    check("pwm_high", hi, 64);
    run_window(4, 0, 1);
    idle(100, 1);
    repeat (30) drv(0, 1, $urandom_range(0, 1), $urandom_range(0, 1), 1);
    idle(PWM_PERIOD, 1);

    // async reset mid-HOLD
    run_window(10, 0, 0);
    idle(2, 0);
    check("hold_valid", cmd_valid, 1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_valid", cmd_valid, 0);
    check("arst_pwm_l", pwm_l, 0);
    check("arst_pwm_r", pwm_r, 0);
    check("arst_left", cmd_left, 0);
    repeat (2) cycle();
    rst = 1'b1;

    // randomized traffic
    do_reset();
    repeat (3000)
      drv($urandom_range(0, 9) != 0, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
